axi_slave_checker: RTL

Synthesizable protocol checker for one AXI4 slave port of `ppu_top`, instantiable once per `slaves[i]` bundle. It passively samples all five channels and tracks outstanding bursts in per-channel FIFOs. It checks burst length against `*_last`, response ordering and IDs, and valid-drop violations, and exposes transaction and beat counters plus sticky error flags. It never drives the bus and can stay in silicon for post-silicon debug.

---
 rtl/axi_slave_checker.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_slave_checker.sv
`default_nettype none
// ============================================================================
// Module : axi_slave_checker
// Passive AXI4 slave-port checker: burst/response tracking, counters, sticky errors.
// Rev    : 1.0  initial release
// ============================================================================
module axi_slave_checker #(
  parameter int ID_WIDTH  = 4,
  parameter int MAX_OUTST = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       aw_valid,
  input  logic                       aw_ready,
  input  logic [7:0]                 aw_len,
  input  logic [ID_WIDTH-1:0]        aw_id,
  input  logic                       w_valid,
  input  logic                       w_ready,
  input  logic                       w_last,
  input  logic                       b_valid,
  input  logic                       b_ready,
  input  logic [ID_WIDTH-1:0]        b_id,
  input  logic [1:0]                 b_resp,
  input  logic                       ar_valid,
  input  logic                       ar_ready,
  input  logic [7:0]                 ar_len,
  input  logic [ID_WIDTH-1:0]        ar_id,
  input  logic                       r_valid,
  input  logic                       r_ready,
  input  logic                       r_last,
  input  logic [ID_WIDTH-1:0]        r_id,
  input  logic [1:0]                 r_resp,
  output logic [CNT_WIDTH-1:0]       aw_cnt_o,
  output logic [CNT_WIDTH-1:0]       ar_cnt_o,
  output logic [CNT_WIDTH-1:0]       b_cnt_o,
  output logic [CNT_WIDTH-1:0]       w_beat_cnt_o,
  output logic [CNT_WIDTH-1:0]       r_beat_cnt_o,
  output logic [$clog2(MAX_OUTST):0] wr_outst_o,
  output logic [$clog2(MAX_OUTST):0] rd_outst_o,
  output logic [9:0]                 err_o,
  output logic                       err_pulse_o
);
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;
  localparam int FW = ID_WIDTH + 8;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] OCC_FULL = CW'(MAX_OUTST);

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [4:0] vld_now, rdy_now;

  logic [FW-1:0]       aw_mem_q [MAX_OUTST];
  logic [FW-1:0]       aw_mem_d [MAX_OUTST];
  logic [PW-1:0]       aw_rd_q, aw_rd_d, aw_wr_q, aw_wr_d;
  logic [CW-1:0]       aw_occ_q, aw_occ_d;
  logic [ID_WIDTH-1:0] b_mem_q [MAX_OUTST];
  logic [ID_WIDTH-1:0] b_mem_d [MAX_OUTST];
  logic [PW-1:0]       b_rd_q, b_rd_d, b_wr_q, b_wr_d;
  logic [CW-1:0]       b_occ_q, b_occ_d;
  logic [FW-1:0]       ar_mem_q [MAX_OUTST];
  logic [FW-1:0]       ar_mem_d [MAX_OUTST];
  logic [PW-1:0]       ar_rd_q, ar_rd_d, ar_wr_q, ar_wr_d;
  logic [CW-1:0]       ar_occ_q, ar_occ_d;

  logic [7:0]          w_idx_q, w_idx_d, r_idx_q, r_idx_d;
  logic [4:0]          vld_q, vld_d, rdy_q, rdy_d;
  logic [CNT_WIDTH-1:0] aw_cnt_q, aw_cnt_d, ar_cnt_q, ar_cnt_d, b_cnt_q, b_cnt_d;
  logic [CNT_WIDTH-1:0] w_beat_q, w_beat_d, r_beat_q, r_beat_d;
  logic [CW-1:0]       wr_outst_q, wr_outst_d, rd_outst_q, rd_outst_d;
  logic [CW:0]         wr_sum;
  logic [9:0]          err_q, err_d, err_new;
  logic                err_pulse_q, err_pulse_d;

  logic                aw_empty, aw_full, aw_avail, aw_pop_ok, aw_push_ok, aw_ovf;
  logic                b_empty, b_full, b_avail, b_trk, b_pop_ok, b_push_ok, b_ovf;
  logic                ar_empty, ar_full, ar_avail, ar_pop_ok, ar_push_ok, ar_ovf;
  logic [FW-1:0]       aw_head, ar_head;
  logic [ID_WIDTH-1:0] b_head;
  logic                w_trk, w_at_len, w_end, r_trk, r_at_len, r_end;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                   input logic inc, input logic clr);
    logic [CNT_WIDTH-1:0] n;
    n = c;
    if (clr) n = '0;
    else if (inc && (c != '1)) n = c + CNT_WIDTH'(1);
    return n;
  endfunction

  always_comb begin
    aw_hs = aw_valid && aw_ready;
    w_hs  = w_valid && w_ready;
    b_hs  = b_valid && b_ready;
    ar_hs = ar_valid && ar_ready;
    r_hs  = r_valid && r_ready;
    vld_now = {aw_valid, w_valid, b_valid, ar_valid, r_valid};
    rdy_now = {aw_ready, w_ready, b_ready, ar_ready, r_ready};

    // An empty FIFO exposes the same-cycle push as its head so it can pass straight through.
    aw_empty = (aw_occ_q == '0);
    aw_full  = (aw_occ_q == OCC_FULL);
    aw_avail = !aw_empty || aw_hs;
    aw_head  = aw_empty ? {aw_id, aw_len} : aw_mem_q[aw_rd_q];

    w_trk    = w_hs && aw_avail;
    w_at_len = (w_idx_q == aw_head[7:0]);
    w_end    = w_trk && (w_last || w_at_len);
    w_idx_d  = w_end ? 8'd0 : (w_trk ? w_idx_q + 8'd1 : w_idx_q);

    aw_pop_ok  = w_end && !aw_empty;
    aw_push_ok = aw_hs && !(w_end && aw_empty) && (!aw_full || aw_pop_ok);
    aw_ovf     = aw_hs && aw_full && !aw_pop_ok;
    aw_mem_d   = aw_mem_q;
    aw_wr_d    = aw_wr_q;
    aw_rd_d    = aw_pop_ok ? aw_rd_q + PTR_ONE : aw_rd_q;
    if (aw_push_ok) begin
      aw_mem_d[aw_wr_q] = {aw_id, aw_len};
      aw_wr_d           = aw_wr_q + PTR_ONE;
    end
    aw_occ_d = aw_occ_q + CW'(aw_push_ok) - CW'(aw_pop_ok);

    b_empty   = (b_occ_q == '0);
    b_full    = (b_occ_q == OCC_FULL);
    b_avail   = !b_empty || w_end;
    b_head    = b_empty ? aw_head[FW-1:8] : b_mem_q[b_rd_q];
    b_trk     = b_hs && b_avail;
    b_pop_ok  = b_trk && !b_empty;
    b_push_ok = w_end && !(b_trk && b_empty) && (!b_full || b_pop_ok);
    b_ovf     = w_end && b_full && !b_pop_ok;
    b_mem_d   = b_mem_q;
    b_wr_d    = b_wr_q;
    b_rd_d    = b_pop_ok ? b_rd_q + PTR_ONE : b_rd_q;
    if (b_push_ok) begin
      b_mem_d[b_wr_q] = aw_head[FW-1:8];
      b_wr_d          = b_wr_q + PTR_ONE;
    end
    b_occ_d = b_occ_q + CW'(b_push_ok) - CW'(b_pop_ok);

    ar_empty = (ar_occ_q == '0);
    ar_full  = (ar_occ_q == OCC_FULL);
    ar_avail = !ar_empty || ar_hs;
    ar_head  = ar_empty ? {ar_id, ar_len} : ar_mem_q[ar_rd_q];

    r_trk    = r_hs && ar_avail;
    r_at_len = (r_idx_q == ar_head[7:0]);
    r_end    = r_trk && (r_last || r_at_len);
    r_idx_d  = r_end ? 8'd0 : (r_trk ? r_idx_q + 8'd1 : r_idx_q);

    ar_pop_ok  = r_end && !ar_empty;
    ar_push_ok = ar_hs && !(r_end && ar_empty) && (!ar_full || ar_pop_ok);
    ar_ovf     = ar_hs && ar_full && !ar_pop_ok;
    ar_mem_d   = ar_mem_q;
    ar_wr_d    = ar_wr_q;
    ar_rd_d    = ar_pop_ok ? ar_rd_q + PTR_ONE : ar_rd_q;
    if (ar_push_ok) begin
      ar_mem_d[ar_wr_q] = {ar_id, ar_len};
      ar_wr_d           = ar_wr_q + PTR_ONE;
    end
    ar_occ_d = ar_occ_q + CW'(ar_push_ok) - CW'(ar_pop_ok);

    err_new[0] = w_trk && (w_last != w_at_len);
    err_new[1] = w_hs && !aw_avail;
    err_new[2] = b_hs && !b_avail;
    err_new[3] = b_trk && (b_id != b_head);
    err_new[4] = r_trk && (r_last != r_at_len);
    err_new[5] = r_hs && !ar_avail;
    err_new[6] = r_trk && (r_id != ar_head[FW-1:8]);
    err_new[7] = aw_ovf || b_ovf || ar_ovf;
    err_new[8] = |(vld_q & ~rdy_q & ~vld_now);
    err_new[9] = (b_hs && (b_resp != 2'b00)) || (r_hs && (r_resp != 2'b00));

    vld_d       = vld_now;
    rdy_d       = rdy_now;
    err_d       = clear_i ? 10'd0 : (err_q | err_new);
    err_pulse_d = !clear_i && |(err_new & ~err_q);

    aw_cnt_d = sat_inc(aw_cnt_q, aw_hs, clear_i);
    ar_cnt_d = sat_inc(ar_cnt_q, ar_hs, clear_i);
    b_cnt_d  = sat_inc(b_cnt_q, b_hs, clear_i);
    w_beat_d = sat_inc(w_beat_q, w_hs, clear_i);
    r_beat_d = sat_inc(r_beat_q, r_hs, clear_i);

    // Both write FIFOs full would need one more bit than the port has; clamp instead of wrapping.
    wr_sum     = {1'b0, aw_occ_d} + {1'b0, b_occ_d};
    wr_outst_d = wr_sum[CW] ? '1 : wr_sum[CW-1:0];
    rd_outst_d = ar_occ_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_mem_q    <= '{default: '0};
      b_mem_q     <= '{default: '0};
      ar_mem_q    <= '{default: '0};
      aw_rd_q     <= '0;
      aw_wr_q     <= '0;
      aw_occ_q    <= '0;
      b_rd_q      <= '0;
      b_wr_q      <= '0;
      b_occ_q     <= '0;
      ar_rd_q     <= '0;
      ar_wr_q     <= '0;
      ar_occ_q    <= '0;
      w_idx_q     <= '0;
      r_idx_q     <= '0;
      vld_q       <= '0;
      rdy_q       <= '0;
      aw_cnt_q    <= '0;
      ar_cnt_q    <= '0;
      b_cnt_q     <= '0;
      w_beat_q    <= '0;
      r_beat_q    <= '0;
      wr_outst_q  <= '0;
      rd_outst_q  <= '0;
      err_q       <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      aw_mem_q    <= aw_mem_d;
      b_mem_q     <= b_mem_d;
      ar_mem_q    <= ar_mem_d;
      aw_rd_q     <= aw_rd_d;
      aw_wr_q     <= aw_wr_d;
      aw_occ_q    <= aw_occ_d;
      b_rd_q      <= b_rd_d;
      b_wr_q      <= b_wr_d;
      b_occ_q     <= b_occ_d;
      ar_rd_q     <= ar_rd_d;
      ar_wr_q     <= ar_wr_d;
      ar_occ_q    <= ar_occ_d;
      w_idx_q     <= w_idx_d;
      r_idx_q     <= r_idx_d;
      vld_q       <= vld_d;
      rdy_q       <= rdy_d;
      aw_cnt_q    <= aw_cnt_d;
      ar_cnt_q    <= ar_cnt_d;
      b_cnt_q     <= b_cnt_d;
      w_beat_q    <= w_beat_d;
      r_beat_q    <= r_beat_d;
      wr_outst_q  <= wr_outst_d;
      rd_outst_q  <= rd_outst_d;
      err_q       <= err_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign aw_cnt_o     = aw_cnt_q;
  assign ar_cnt_o     = ar_cnt_q;
  assign b_cnt_o      = b_cnt_q;
  assign w_beat_cnt_o = w_beat_q;
  assign r_beat_cnt_o = r_beat_q;
  assign wr_outst_o   = wr_outst_q;
  assign rd_outst_o   = rd_outst_q;
  assign err_o        = err_q;
  assign err_pulse_o  = err_pulse_q;
endmodule
`default_nettype wire
